ahb_mchan_fifo: RTL and testbench

- AHB-Lite slave bridging the bus into NCH independent synchronous FIFOs, all clocked on hclk.
- Successor to the single-channel AHB FIFO interface: data width, depth and channel count are parametrised.
- Adds per-channel status and flush registers, plus AHB ERROR responses on overflow, underflow and bad decode.
- Sits behind the system decoder (hsel) and feeds producer/consumer software queues.

---
 rtl/ahb_mchan_fifo_if.sv | 26 ++
 rtl/ahb_mchan_fifo.sv | 154 +++++++++++++++
 tb/tb_ahb_mchan_fifo.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_mchan_fifo_if.sv
// AHB-Lite slave-side bus bundle for the multi-channel FIFO bridge.
// master drives hsel/haddr/hburst/htrans/hwrite/hwdata; slave drives hrdata/hready/hresp.
interface ahb_mchan_fifo_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 20
);
  logic              hsel;
  logic [AWIDTH-1:0] haddr;
  logic [2:0]        hburst;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [DWIDTH-1:0] hwdata;
  logic [DWIDTH-1:0] hrdata;
  logic              hready;
  logic [1:0]        hresp;

  modport master (
    output hsel, haddr, hburst, htrans, hwrite, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, hburst, htrans, hwrite, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_mchan_fifo.sv
// AHB-Lite slave in front of NCH synchronous FIFOs with DATA/STATUS/CTRL regs.
// Ports: hclk, hreset (sync, active-low), bus (slave modport), ch_empty, ch_full.
module ahb_mchan_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16,
  parameter int NCH    = 4,
  parameter int AWIDTH = 20
) (
  input  logic           hclk,
  input  logic           hreset,
  ahb_mchan_fifo_if.slave bus,
  output logic [NCH-1:0] ch_empty,
  output logic [NCH-1:0] ch_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR2
  } state_t;

  state_t state, state_nx;

  logic       ph_write;
  logic [3:0] ph_ch;
  logic [1:0] ph_off;

  logic [DWIDTH-1:0] mem [NCH][DEPTH];
  logic [PW-1:0]     wptr [NCH];
  logic [PW-1:0]     rptr [NCH];
  logic [CW-1:0]     cnt  [NCH];

  logic [XW-1:0]     ci;
  logic              ch_ok;
  logic              is_full;
  logic              is_empty;
  logic              err;
  logic              accept;
  logic              do_push;
  logic              do_pop;
  logic              do_flush;
  logic              rdy;
  logic [1:0]        resp;
  logic [DWIDTH-1:0] rdata;
  logic [DWIDTH-1:0] status;
  logic              unused;

  assign unused = ^{bus.hburst, bus.htrans[0],
                    bus.haddr[AWIDTH-1:8], bus.haddr[1:0]};

  assign ci       = ph_ch[XW-1:0];
  assign ch_ok    = ({1'b0, ph_ch} < 5'(NCH));
  // Gated by ch_ok so an out-of-range channel never reads a bogus count.
  assign is_full  = ch_ok && (cnt[ci] == CW'(DEPTH));
  assign is_empty = ch_ok && (cnt[ci] == '0);

  always_comb begin
    status = '0;
    if (ch_ok) begin
      status[0]      = is_empty;
      status[1]      = is_full;
      status[8 +: CW] = cnt[ci];
    end
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b1;
    resp     = 2'b00;
    rdata    = '0;
    err      = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_flush = 1'b0;
    unique case (state)
      S_DATA: begin
        err = !ch_ok || (ph_off == 2'd3) ||
              ((ph_off == 2'd0) && ph_write && is_full) ||
              ((ph_off == 2'd0) && !ph_write && is_empty);
        if (err) begin
          rdy  = 1'b0;
          resp = 2'b01;
        end else begin
          do_push  = (ph_off == 2'd0) && ph_write;
          do_pop   = (ph_off == 2'd0) && !ph_write;
          do_flush = (ph_off == 2'd2) && ph_write && bus.hwdata[0];
          if (do_pop)
            rdata = mem[ci][rptr[ci]];
          else if ((ph_off == 2'd1) && !ph_write)
            rdata = status;
        end
      end
      S_ERR2: resp = 2'b01;
      default: ;
    endcase
    accept = bus.hsel && rdy && bus.htrans[1];
    // E1 is the failing data phase itself; E2 may accept a new address.
    if (err)
      state_nx = S_ERR2;
    else
      state_nx = accept ? S_DATA : S_IDLE;
  end

  assign bus.hready = rdy;
  assign bus.hresp  = resp;
  assign bus.hrdata = rdata;

  always_ff @(posedge hclk) begin
    if (!hreset) begin
      state    <= S_IDLE;
      ph_write <= 1'b0;
      ph_ch    <= '0;
      ph_off   <= '0;
      for (int i = 0; i < NCH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      state <= state_nx;
      if (accept) begin
        ph_write <= bus.hwrite;
        ph_ch    <= bus.haddr[7:4];
        ph_off   <= bus.haddr[3:2];
      end
      if (do_push) begin
        wptr[ci] <= wptr[ci] + 1'b1;
        cnt[ci]  <= cnt[ci] + 1'b1;
      end
      if (do_pop) begin
        rptr[ci] <= rptr[ci] + 1'b1;
        cnt[ci]  <= cnt[ci] - 1'b1;
      end
      if (do_flush) begin
        wptr[ci] <= '0;
        rptr[ci] <= '0;
        cnt[ci]  <= '0;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset && do_push)
      mem[ci][wptr[ci]] <= bus.hwdata;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_flag
    assign ch_empty[g] = (cnt[g] == '0);
    assign ch_full[g]  = (cnt[g] == CW'(DEPTH));
  end
endmodule

// File: tb/tb_ahb_mchan_fifo.sv
// Scoreboard bench for ahb_mchan_fifo: pipelined AHB driver plus FIFO model.
// Ports: none; drives the bus interface and checks hrdata/hready/hresp/flags.
module tb_ahb_mchan_fifo;
  logic       hclk = 1'b0;
  logic       hreset = 1'b0;
  logic [3:0] ch_empty;
  logic [3:0] ch_full;

  int total = 0;
  int bad = 0;

  always #5 hclk = ~hclk;

  ahb_mchan_fifo_if #(.DWIDTH(32), .AWIDTH(20)) bif ();

  ahb_mchan_fifo #(
    .DWIDTH(32), .DEPTH(16), .NCH(4), .AWIDTH(20)
  ) dut (
    .hclk(hclk),
    .hreset(hreset),
    .bus(bif.slave),
    .ch_empty(ch_empty),
    .ch_full(ch_full)
  );

  typedef struct {
    bit          wr;
    int          ch;
    int          off;
    logic [31:0] wd;
  } op_t;

  typedef struct {
    bit          err;
    logic [31:0] rd;
  } exp_t;

  op_t         ops[$];
  exp_t        sb[$];
  logic [31:0] mq[16][$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add(bit wr, int ch, int off, logic [31:0] wd);
    op_t o;
    o.wr = wr; o.ch = ch; o.off = off; o.wd = wd;
    ops.push_back(o);
  endtask

  // Reference behaviour applied in issue order; result goes to the scoreboard.
  task automatic model(input op_t o);
    exp_t e;
    int   n;
    e.err = 1'b0;
    e.rd  = '0;
    if (o.ch >= 4 || o.off == 3) begin
      e.err = 1'b1;
    end else begin
      n = mq[o.ch].size();
      if (o.off == 0 && o.wr) begin
        if (n == 16) e.err = 1'b1;
        else mq[o.ch].push_back(o.wd);
      end else if (o.off == 0) begin
        if (n == 0) e.err = 1'b1;
        else e.rd = mq[o.ch].pop_front();
      end else if (o.off == 1 && !o.wr) begin
        e.rd = (32'(n) << 8) | ((n == 16) ? 32'h2 : 32'h0) |
               ((n == 0) ? 32'h1 : 32'h0);
      end else if (o.off == 2 && o.wr && o.wd[0]) begin
        mq[o.ch].delete();
      end
    end
    sb.push_back(e);
  endtask

  task automatic chk_flags(string tag);
    logic [3:0] fe, ff;
    for (int c = 0; c < 4; c++) begin
      fe[c] = (mq[c].size() == 0);
      ff[c] = (mq[c].size() == 16);
    end
    chk({tag, "_empty"}, 32'(ch_empty), 32'(fe));
    chk({tag, "_full"}, 32'(ch_full), 32'(ff));
  endtask

  task automatic bus_idle();
    bif.hsel   = 1'b0;
    bif.htrans = 2'b00;
    bif.hwrite = 1'b0;
    bif.haddr  = '0;
  endtask

  task automatic drive_addr(op_t o, bit seq);
    bif.hsel   = 1'b1;
    bif.htrans = seq ? 2'b11 : 2'b10;
    bif.hwrite = o.wr;
    bif.hburst = 3'b001;
    bif.haddr  = 20'({o.ch[3:0], o.off[1:0], 2'b00});
  endtask

  // Runs ops[] back-to-back; call just after a posedge.
  task automatic run_ops(string tag);
    bit   dp = 0;
    bit   seq = 0;
    op_t  d;
    exp_t e;
    int   guard = 0;
    while ((ops.size() > 0 || dp) && guard < 2000) begin
      guard++;
      if (ops.size() > 0) drive_addr(ops[0], seq);
      else bus_idle();
      if (dp) bif.hwdata = d.wd;
      @(negedge hclk);
      if (dp) begin
        e = sb.pop_front();
        if (e.err) begin
          chk({tag, "_e1_rdy"}, 32'(bif.hready), 32'd0);
          chk({tag, "_e1_resp"}, 32'(bif.hresp), 32'd1);
          chk({tag, "_e1_rd"}, bif.hrdata, 32'd0);
          @(posedge hclk); #1;
          @(negedge hclk);
          chk({tag, "_e2_rdy"}, 32'(bif.hready), 32'd1);
          chk({tag, "_e2_resp"}, 32'(bif.hresp), 32'd1);
        end else begin
          chk({tag, "_rdy"}, 32'(bif.hready), 32'd1);
          chk({tag, "_resp"}, 32'(bif.hresp), 32'd0);
          chk({tag, "_rd"}, bif.hrdata, e.rd);
        end
      end
      if (ops.size() > 0) begin
        d = ops.pop_front();
        model(d);
        dp = 1;
        seq = 1;
      end else begin
        dp = 0;
      end
      @(posedge hclk); #1;
    end
    if (guard >= 2000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=%0d exp=<2000", tag, guard);
    end
    bus_idle();
    chk_flags(tag);
  endtask

  initial begin
    bus_idle();
    bif.hburst = 3'b000;
    bif.hwdata = '0;
    hreset = 1'b0;
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b1;
    @(negedge hclk);
    chk("rst_rdy", 32'(bif.hready), 32'd1);
    chk("rst_resp", 32'(bif.hresp), 32'd0);
    chk("rst_rd", bif.hrdata, 32'd0);
    chk("rst_empty", 32'(ch_empty), 32'hf);
    chk("rst_full", 32'(ch_full), 32'h0);
    @(posedge hclk); #1;

    add(0, 0, 1, 0);
    run_ops("stat0");

    for (int i = 1; i <= 3; i++) add(1, 2, 0, 32'hA5A5_0000 + 32'(i));
    add(0, 2, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 2, 0, 0);
    add(0, 2, 1, 0);
    run_ops("ch2");

    for (int i = 0; i < 16; i++) add(1, 1, 0, 32'h1100_0000 + 32'(i));
    add(1, 1, 0, 32'hDEAD_BEEF);
    add(0, 1, 1, 0);
    run_ops("fill1");
    add(0, 1, 0, 0);
    run_ops("pop1");
    for (int i = 0; i < 15; i++) add(0, 1, 0, 0);
    add(0, 1, 1, 0);
    run_ops("drain1");

    add(1, 3, 0, 32'h3333_0000);
    add(0, 3, 0, 0);
    add(0, 3, 0, 0);
    add(0, 5, 1, 0);
    add(1, 5, 0, 32'h5555_5555);
    add(0, 0, 3, 0);
    add(1, 0, 3, 32'h1);
    add(0, 3, 1, 0);
    add(0, 0, 1, 0);
    run_ops("errs");

    for (int i = 0; i < 24; i++) begin
      add(1, 0, 0, 32'hC000_0000 + 32'(i));
      add(0, 0, 1, 0);
      add(0, 0, 0, 0);
    end
    run_ops("wrap");

    for (int i = 0; i < 5; i++) add(1, 0, 0, 32'h0F00_0000 + 32'(i));
    add(0, 0, 1, 0);
    add(1, 2, 0, 32'h2222_2222);
    add(1, 2, 2, 32'h0);
    add(0, 2, 1, 0);
    add(0, 0, 2, 0);
    add(1, 0, 1, 32'hFFFF_FFFF);
    add(1, 0, 2, 32'h1);
    add(0, 0, 1, 0);
    run_ops("flush");

    // Abandon an error sequence with reset asserted during E1.
    drive_addr('{wr: 1'b0, ch: 3, off: 0, wd: '0}, 1'b0);
    @(posedge hclk); #1;
    bus_idle();
    hreset = 1'b0;
    @(negedge hclk);
    chk("rst_e1_rdy", 32'(bif.hready), 32'd0);
    chk("rst_e1_resp", 32'(bif.hresp), 32'd1);
    @(posedge hclk); #1;
    hreset = 1'b1;
    for (int c = 0; c < 16; c++) mq[c].delete();
    @(negedge hclk);
    chk("rst2_rdy", 32'(bif.hready), 32'd1);
    chk("rst2_resp", 32'(bif.hresp), 32'd0);
    chk_flags("rst2");
    @(posedge hclk); #1;
    add(0, 2, 1, 0);
    add(0, 0, 1, 0);
    run_ops("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
